// File: rtl/icache_direct.sv
// Direct-mapped instruction cache with one-word lines. Hits return in one cycle;
// a miss issues a single word fetch to the memory controller and fills the line.
module icache_direct #(
   parameter int INDEX_BITS = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        rollback,
   input  logic [31:0] fetch_pc,
   input  logic        fetch_req,
   output logic        ins_valid,
   output logic [31:0] ins_out,
   output logic [31:0] mem_pc,
   output logic        mem_miss_sgn,
   input  logic        mem_finish,
   input  logic [31:0] mem_ins
);
   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = 30 - INDEX_BITS;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] MISS = 1'b1;

   logic [0:0]            state;
   logic [LINES-1:0]      valid;
   logic [TAG_W-1:0]      tag_arr  [LINES];
   logic [31:0]           data_arr [LINES];

   logic [INDEX_BITS-1:0] idx;
   logic [INDEX_BITS-1:0] miss_idx;
   logic [TAG_W-1:0]      tag;
   logic [TAG_W-1:0]      miss_tag;
   logic                  hit;
   logic                  fill;
   logic                  unused_pc_bits;

   assign idx            = fetch_pc[INDEX_BITS+1:2];
   assign tag            = fetch_pc[31:INDEX_BITS+2];
   assign unused_pc_bits = ^fetch_pc[1:0];

   // mem_pc doubles as the miss register: its index/tag fields address the fill.
   assign miss_idx = mem_pc[INDEX_BITS+1:2];
   assign miss_tag = mem_pc[31:INDEX_BITS+2];

   assign hit  = valid[idx] && (tag_arr[idx] == tag);
   assign fill = rst && rdy && !rollback && (state == MISS) && mem_finish;

   // Dropping the request in the finish cycle keeps the controller from restarting it.
   assign mem_miss_sgn = (state == MISS) && !mem_finish;

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid     <= '0;
         state     <= IDLE;
         ins_valid <= 1'b0;
         ins_out   <= '0;
         mem_pc    <= '0;
      end else if (rdy) begin
         if (rollback) begin
            state     <= IDLE;
            ins_valid <= 1'b0;
         end else if (state == IDLE) begin
            if (fetch_req && hit) begin
               ins_out   <= data_arr[idx];
               ins_valid <= 1'b1;
            end else if (fetch_req) begin
               mem_pc    <= {fetch_pc[31:2], 2'b00};
               state     <= MISS;
               ins_valid <= 1'b0;
            end else begin
               ins_valid <= 1'b0;
            end
         end else if (mem_finish) begin
            valid[miss_idx] <= 1'b1;
            ins_out         <= mem_ins;
            ins_valid       <= 1'b1;
            state           <= IDLE;
         end
      end
   end

   // Tag/data arrays carry no reset; the valid bits alone gate their use.
   always_ff @(posedge clk) begin
      if (fill) begin
         tag_arr[miss_idx]  <= miss_tag;
         data_arr[miss_idx] <= mem_ins;
      end
   end

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios plus randomized fetches
// against a slot-contents reference model and a restart-on-idle memory controller model.
module tb_icache_direct;
   localparam int LINES = 64;

   logic        clk = 1'b0;
   logic        rst, rdy, rollback, fetch_req, mem_finish;
   logic [31:0] fetch_pc, mem_ins;
   logic        ins_valid, mem_miss_sgn;
   logic [31:0] ins_out, mem_pc;

   int n_checks = 0;
   int n_errors = 0;

   // Reference: which word address each slot holds, and its contents.
   bit          m_valid [LINES];
   logic [29:0] m_waddr [LINES];
   logic [31:0] m_data  [LINES];

   icache_direct #(.INDEX_BITS(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .rdy          (rdy),
      .rollback     (rollback),
      .fetch_pc     (fetch_pc),
      .fetch_req    (fetch_req),
      .ins_valid    (ins_valid),
      .ins_out      (ins_out),
      .mem_pc       (mem_pc),
      .mem_miss_sgn (mem_miss_sgn),
      .mem_finish   (mem_finish),
      .mem_ins      (mem_ins)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
      $fatal(1, "watchdog expired");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input logic obs, input logic want, input string nm);
      n_checks++;
      assert (obs === want) else begin
         n_errors++;
         $error("FAIL %s: observed=%b expected=%b", nm, obs, want);
      end
   endtask

   task automatic chk32(input logic [31:0] obs, input logic [31:0] want, input string nm);
      n_checks++;
      assert (obs === want) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", nm, obs, want);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
   endtask

   function automatic int slot(input logic [31:0] pc);
      return int'((pc >> 2) % 32'(LINES));
   endfunction

   // One fetch transaction; a miss is served by a controller that starts a fetch
   // whenever it sees mem_miss_sgn while idle (the finish cycle counts as idle).
   task automatic do_fetch(input logic [31:0] pc, input logic [31:0] word, input int lat,
                           input int stall, input bit hold);
      int s, busy, fetches;
      bit exp_hit, done, fin;
      s       = slot(pc);
      exp_hit = m_valid[s] && (m_waddr[s] == pc[31:2]);
      fetch_pc   = pc;
      fetch_req  = 1'b1;
      mem_finish = 1'b0;
      cyc();
      if (exp_hit) begin
         chk1(ins_valid, 1'b1, "hit_valid");
         chk32(ins_out, m_data[s], "hit_data");
         chk1(mem_miss_sgn, 1'b0, "hit_no_miss");
      end else begin
         chk1(ins_valid, 1'b0, "miss_valid_low");
         chk1(mem_miss_sgn, 1'b1, "miss_sgn");
         chk32(mem_pc, {pc[31:2], 2'b00}, "miss_pc");
         busy = -1; fetches = 0; done = 1'b0;
         for (int c = 0; c < 400 && !done; c++) begin
            if (c == 1 && stall > 0) begin
               rdy = 1'b0; mem_finish = 1'b1; mem_ins = $urandom;
               for (int k = 0; k < stall; k++) begin
                  cyc();
                  chk1(ins_valid, 1'b0, "stall_valid");
                  chk1(mem_miss_sgn, 1'b0, "stall_sgn_fin");
                  chk32(mem_pc, {pc[31:2], 2'b00}, "stall_pc");
               end
               rdy = 1'b1; mem_finish = 1'b0;
            end
            fin        = (busy == 0);
            mem_finish = fin;
            mem_ins    = fin ? word : $urandom;
            #1;
            if (fin) chk1(mem_miss_sgn, 1'b0, "fin_sgn_low");
            else if (busy > 0) chk1(mem_miss_sgn, 1'b1, "wait_sgn");
            if (busy <= 0) begin
               if (mem_miss_sgn) begin
                  fetches++;
                  busy = lat;
               end else begin
                  busy = -1;
               end
            end else begin
               busy--;
            end
            cyc();
            if (fin) done = 1'b1;
         end
         mem_finish = 1'b0;
         chk1(done, 1'b1, "miss_timeout");
         chk32(fetches, 32'd1, "one_fetch");
         chk1(ins_valid, 1'b1, "fill_valid");
         chk32(ins_out, word, "fill_data");
         chk1(mem_miss_sgn, 1'b0, "fill_idle");
         m_valid[s] = 1'b1;
         m_waddr[s] = pc[31:2];
         m_data[s]  = word;
      end
      if (hold) begin
         cyc();
         chk1(ins_valid, 1'b1, "hold_hit_valid");
         chk32(ins_out, m_data[s], "hold_hit_data");
         chk1(mem_miss_sgn, 1'b0, "hold_no_miss");
      end
      fetch_req = 1'b0;
      cyc();
      chk1(ins_valid, 1'b0, "valid_pulse_end");
   endtask

   initial begin
      logic [31:0] rpc;
      logic [31:0] rword;
      bit          rhold;
      rst = 1'b0; rdy = 1'b1; rollback = 1'b0; fetch_req = 1'b0;
      mem_finish = 1'b0; fetch_pc = '0; mem_ins = '0;
      model_reset();
      cyc(); cyc();
      chk1(ins_valid, 1'b0, "rst_valid");
      chk32(ins_out, 32'h0, "rst_out");
      chk32(mem_pc, 32'h0, "rst_pc");
      chk1(mem_miss_sgn, 1'b0, "rst_sgn");
      rst = 1'b1;

      // Cold miss, then hit
      do_fetch(32'h0000_0010, 32'h0000_0513, 6, 0, 1'b0);
      do_fetch(32'h0000_0010, 32'h0, 6, 0, 1'b0);

      // Conflict eviction on the same index
      do_fetch(32'h0000_0110, 32'hDEAD_BEEF, 7, 0, 1'b0);
      do_fetch(32'h0000_0010, 32'h0000_0513, 6, 0, 1'b0);

      // ins_valid holds while rdy is low
      fetch_pc = 32'h0000_0010; fetch_req = 1'b1; cyc();
      chk1(ins_valid, 1'b1, "rdyhold_hit");
      rdy = 1'b0; fetch_req = 1'b0; cyc();
      chk1(ins_valid, 1'b1, "rdyhold_valid");
      rdy = 1'b1; cyc();
      chk1(ins_valid, 1'b0, "rdyhold_release");

      // Rollback mid-miss, then a late finish in IDLE
      fetch_pc = 32'h0000_0020; fetch_req = 1'b1; cyc();
      chk1(mem_miss_sgn, 1'b1, "rb_miss_start");
      fetch_req = 1'b0; cyc(); cyc();
      rollback = 1'b1; cyc(); rollback = 1'b0;
      chk1(ins_valid, 1'b0, "rb_valid");
      chk1(mem_miss_sgn, 1'b0, "rb_sgn");
      mem_finish = 1'b1; mem_ins = 32'hBAD0_0BAD; cyc(); mem_finish = 1'b0;
      chk1(ins_valid, 1'b0, "late_fin_valid");
      do_fetch(32'h0000_0020, 32'h0020_0093, 8, 0, 1'b0);

      // Rollback coinciding with mem_finish must not fill
      fetch_pc = 32'h0000_0024; fetch_req = 1'b1; cyc();
      chk1(mem_miss_sgn, 1'b1, "rb2_start");
      rollback = 1'b1; mem_finish = 1'b1; mem_ins = 32'h1111_1111; cyc();
      rollback = 1'b0; mem_finish = 1'b0; fetch_req = 1'b0;
      chk1(ins_valid, 1'b0, "rb2_valid");
      chk1(mem_miss_sgn, 1'b0, "rb2_sgn");
      do_fetch(32'h0000_0024, 32'h0024_0013, 6, 0, 1'b0);

      // Rollback in IDLE drops a same-cycle request
      fetch_pc = 32'h0000_0028; fetch_req = 1'b1; rollback = 1'b1; cyc();
      rollback = 1'b0; fetch_req = 1'b0;
      chk1(mem_miss_sgn, 1'b0, "rb_req_ignored");
      cyc();

      // rdy stall during a miss
      do_fetch(32'h0000_0030, 32'h0030_0113, 6, 5, 1'b0);

      // Duplicate-fetch guard with fetch_req held
      do_fetch(32'h0000_0040, 32'h0040_0237, 6, 0, 1'b1);

      // Reset mid-operation
      do_fetch(32'h0000_0100, 32'hA000_0001, 6, 0, 1'b0);
      do_fetch(32'h0000_0204, 32'hA000_0002, 6, 0, 1'b0);
      do_fetch(32'h0000_0308, 32'hA000_0003, 6, 0, 1'b0);
      do_fetch(32'h0000_040C, 32'hA000_0004, 6, 0, 1'b0);
      fetch_pc = 32'h0000_0500; fetch_req = 1'b1; cyc();
      chk1(mem_miss_sgn, 1'b1, "rstmid_miss");
      fetch_req = 1'b0; rst = 1'b0; cyc(); rst = 1'b1;
      chk1(ins_valid, 1'b0, "rstmid_valid");
      chk32(ins_out, 32'h0, "rstmid_out");
      chk32(mem_pc, 32'h0, "rstmid_pc");
      chk1(mem_miss_sgn, 1'b0, "rstmid_sgn");
      model_reset();
      do_fetch(32'h0000_0100, 32'hB000_0001, 6, 0, 1'b0);
      do_fetch(32'h0000_0204, 32'hB000_0002, 6, 0, 1'b0);
      do_fetch(32'h0000_0308, 32'hB000_0003, 6, 0, 1'b0);
      do_fetch(32'h0000_040C, 32'hB000_0004, 6, 0, 1'b0);

      // Randomized fetches over a small address pool to mix hits and conflicts
      for (int i = 0; i < 60; i++) begin
         rpc   = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
         rword = $urandom;
         rhold = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) begin
            fetch_req = 1'b0; mem_finish = 1'($urandom_range(0, 1)); mem_ins = $urandom;
            cyc();
            mem_finish = 1'b0;
            chk1(ins_valid, 1'b0, "noise_valid");
            chk1(mem_miss_sgn, 1'b0, "noise_sgn");
         end
         do_fetch(rpc, rword, 5 + int'($urandom_range(0, 6)), 0, rhold);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped instruction cache between the instruction fetch unit and the memory controller. Serves fetch requests from an internal tag/data array in one cycle on a hit. On a miss it issues a single 32-bit instruction fetch to the memory controller, fills the line, and returns the word. The memory controller arbitrates fetches at lowest priority behind stores and loads, so miss latency is variable.

## Interface

- INDEX_BITS, 6, index width; the cache holds 2^INDEX_BITS one-word lines.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on the rising edge).
- rdy  input  1  global ready; when 0, all state and outputs hold.
- rollback  input  1  pipeline flush from ROB; aborts any outstanding miss.
- fetch_pc  input  32  instruction address, word-aligned (bits [1:0] ignored).
- fetch_req  input  1  fetch request; held with a stable fetch_pc until ins_valid.
- ins_valid  output  1  one-cycle pulse: ins_out holds the word for the current fetch_pc.
- ins_out  output  32  returned instruction.
- mem_pc  output  32  miss address to the memory controller; {fetch_pc[31:2], 2'b00} latched at miss.
- mem_miss_sgn  output  1  fetch request to the memory controller.
- mem_finish  input  1  memory controller fetch complete (finish_ins).
- mem_ins  input  32  fetched word, valid while mem_finish is 1.

## Operation

- Address split:
  - index = fetch_pc[INDEX_BITS+1:2]
  - tag = fetch_pc[31:INDEX_BITS+2]
- Per-line storage:
  - valid bit
  - tag
  - 32-bit data word
- States are IDLE and MISS.
- IDLE, fetch_req=1, hit (valid[index] and tag match):
  - ins_out <= data[index]
  - ins_valid <= 1
  - Stay in IDLE.
- IDLE, fetch_req=1, miss:
  - Latch mem_pc and the index/tag into a miss register.
  - Go to MISS.
  - ins_valid <= 0.
- IDLE, fetch_req=0: ins_valid <= 0.
- MISS:
  - mem_miss_sgn = (state==MISS) && !mem_finish. This is combinational, so the request drops in the same cycle mem_finish is seen and the controller never restarts a duplicate fetch on its next idle cycle.
  - On mem_finish=1, write valid/tag/data at the latched index, set ins_out <= mem_ins and ins_valid <= 1, and go to IDLE.
  - fetch_req and fetch_pc are not re-examined while in MISS.
- mem_finish in IDLE is ignored (no array write).
- rollback=1 (with rst=1 and rdy=1):
  - Go to IDLE, ins_valid <= 0, and do not fill.
  - Array contents and valid bits are kept.
  - A fetch_req in the same cycle is ignored.
  - mem_finish in the same cycle is ignored.
- rst=0:
  - All valid bits <= 0, state <= IDLE.
  - ins_valid <= 0, ins_out <= 0, mem_pc <= 0.
  - Consequently mem_miss_sgn = 0.
  - rst takes priority over rollback and rdy.
- rdy=0 (rst=1): no state change.
  - mem_miss_sgn keeps its combinational value.
  - ins_valid holds its previous value; the consumer qualifies it with rdy.
- No write path: self-modifying code is not supported. Stores never invalidate lines.

## Timing

- Hit: fetch_req sampled at edge N, ins_valid=1 during cycle N..N+1 (1-cycle latency).
- Back-to-back hits:
  - The consumer changes fetch_pc after seeing ins_valid. The next request can be sampled on the following edge.
  - Sustained rate is one instruction per two cycles when the fetch unit is registered, or one per cycle if it advances combinationally on ins_valid.
- Miss:
  - Edge N samples the miss and mem_miss_sgn rises in cycle N..N+1.
  - The controller then takes at least 6 cycles (idle sample plus 5 byte cycles) when uncontended, and longer when stores or loads win arbitration.
  - ins_valid rises on the edge that samples mem_finish=1.
- mem_pc is stable from the miss edge until the return to IDLE.
- Reset values:
  - ins_valid=0, ins_out=0, mem_pc=0, mem_miss_sgn=0
  - state=IDLE, all lines invalid

## Test plan

- **Cold miss, then hit.** Release reset, set fetch_pc=0x0000_0010 with fetch_req=1. Expect mem_miss_sgn=1 and mem_pc=0x10. Drive mem_finish with mem_ins=0x0000_0513. Expect ins_valid pulse with ins_out=0x513 and mem_miss_sgn=0 in the finish cycle. Re-request 0x10: expect ins_valid one edge later and no mem_miss_sgn.
- **Conflict eviction (INDEX_BITS=6).** Fill 0x0000_0010, then request 0x0000_0110 (same index, different tag). Expect a miss and fill with 0xDEAD_BEEF. Request 0x10 again: expect a miss, i.e. the line was replaced.
- **Rollback mid-miss.** Start a miss at 0x20 and assert rollback for one cycle before mem_finish. Expect state IDLE, ins_valid=0, mem_miss_sgn=0. A following request to 0x20 must miss again (no stale fill). A late mem_finish pulse in IDLE must not write the array.
- **rdy stall.** During MISS hold rdy=0 for 5 cycles. Expect the state and mem_pc unchanged. After rdy returns, the fill completes normally with the correct data.
- **Reset mid-operation.** Fill 4 lines, start a miss, then assert rst=0 for one edge. Expect all outputs at reset values. Requests to all 4 previously filled addresses must miss.
- **Duplicate-fetch guard.** Hold fetch_req=1 on a miss with a memory controller model that restarts whenever mem_miss_sgn is high in its idle cycle. Expect exactly one fetch per miss, and mem_miss_sgn=0 in the cycle mem_finish=1.
